spi_responder: RTL and testbench

SPI mode-0 responder (slave) modelling the accelerometer end of the link driven by the team's `spi` master. It decodes the 0x0A write and 0x0B read command framing on a system-clock-oversampled `sclk`/`cs`/`mosi`, with auto-incrementing addressing. It serves an internal 64-entry byte register map and exposes POWER_CTL to downstream logic. It is used as a synthesizable loopback target and as the bench partner for the master.

---
 rtl/spi_resp_pkg.sv | 32 +++
 rtl/spi_edge_sync.sv | 32 +++
 rtl/spi_responder.sv | 171 +++++++++++++++++
 tb/tb_spi_responder.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_resp_pkg.sv
// Shared types and register-map constants for the SPI responder.
package spi_resp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DATA_WR,
    DATA_RD,
    IGNORE
  } resp_state_t;

  localparam logic [7:0] CMD_WRITE    = 8'h0A;
  localparam logic [7:0] CMD_READ     = 8'h0B;
  localparam logic [7:0] SOFT_RST_KEY = 8'h52;
  localparam logic [7:0] DEVID_ALT    = 8'h1D;

  localparam logic [5:0] ADDR_DEVID      = 6'h00;
  localparam logic [5:0] ADDR_DEVID_ALT  = 6'h01;
  localparam logic [5:0] ADDR_XDATA      = 6'h08;
  localparam logic [5:0] ADDR_YDATA      = 6'h09;
  localparam logic [5:0] ADDR_ZDATA      = 6'h0A;
  localparam logic [5:0] ADDR_SOFT_RST   = 6'h1F;
  localparam logic [5:0] ADDR_SCRATCH_LO = 6'h20;
  localparam logic [5:0] ADDR_SCRATCH_HI = 6'h2C;
  localparam logic [5:0] ADDR_POWER_CTL  = 6'h2D;

  function automatic logic is_scratch(input logic [5:0] addr);
    return (addr >= ADDR_SCRATCH_LO) && (addr <= ADDR_SCRATCH_HI);
  endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// N-flop synchronizer for one SPI pin, with rise/fall pulses on the synchronized level.
module spi_edge_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_responder.sv
// SPI mode-0 responder with a 64-entry byte register map and auto-incrementing pointer.
// Optional soft reset at 0x1F is enabled by defining SPI_RESP_SOFT_RST_EN.
module spi_responder
  import spi_resp_pkg::*;
#(
  parameter logic [7:0] DEVID       = 8'hAD,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       cs,
  input  logic       mosi,
  input  logic [7:0] x_data,
  input  logic [7:0] y_data,
  input  logic [7:0] z_data,
  output logic       miso,
  output logic [7:0] power_ctl,
  output logic       soft_rst,
  output logic       busy
);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;

  spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d(sclk), .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );
  spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .d(cs), .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );
  spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .d(mosi), .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall)
  );

  // Frame control works from the cs level; edge pulses other than sclk are not needed.
  logic unused_edges;
  assign unused_edges = &{1'b0, sclk_lvl, cs_rise, cs_fall, mosi_rise, mosi_fall};

  resp_state_t state_q;
  logic        write_mode_q;
  logic [2:0]  bit_cnt_q;
  logic [6:0]  shift_in_q;
  logic [7:0]  shift_out_q;
  logic [5:0]  ptr_q;
  logic [7:0]  scratch_q [ADDR_SCRATCH_LO:ADDR_SCRATCH_HI];
  logic [7:0]  power_ctl_q;
  logic        busy_q;

  logic       in_frame;
  logic       byte_done;
  logic [7:0] rx_byte;
  logic [5:0] rd_addr;
  logic [7:0] rd_data;
  logic       wr_en;
  logic       soft_hit;

  // A cs release on the same cycle as the 8th rise masks byte_done, so the byte is dropped.
  assign in_frame  = ~cs_lvl;
  assign byte_done = in_frame & sclk_rise & (bit_cnt_q == 3'd7);
  assign rx_byte   = {shift_in_q, mosi_lvl};
  assign wr_en     = byte_done & (state_q == DATA_WR);
  // The first read byte is fetched from the address being received, later ones from the pointer.
  assign rd_addr   = (state_q == ADDR) ? rx_byte[5:0] : ptr_q;

  // NOTE: default assignment first so no path through this block infers a latch.
  always_comb begin
    rd_data = 8'h00;
    if (rd_addr == ADDR_DEVID)           rd_data = DEVID;
    else if (rd_addr == ADDR_DEVID_ALT)  rd_data = DEVID_ALT;
    else if (rd_addr == ADDR_XDATA)      rd_data = x_data;
    else if (rd_addr == ADDR_YDATA)      rd_data = y_data;
    else if (rd_addr == ADDR_ZDATA)      rd_data = z_data;
    else if (is_scratch(rd_addr))        rd_data = scratch_q[rd_addr];
    else if (rd_addr == ADDR_POWER_CTL)  rd_data = power_ctl_q;
  end

`ifdef SPI_RESP_SOFT_RST_EN
  logic soft_rst_q;
  assign soft_hit = wr_en & (ptr_q == ADDR_SOFT_RST) & (rx_byte == SOFT_RST_KEY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) soft_rst_q <= 1'b0;
    else        soft_rst_q <= soft_hit;
  end
  assign soft_rst = soft_rst_q;
`else
  assign soft_hit = 1'b0;
  assign soft_rst = 1'b0;
`endif

  // NOTE: the register file is small and must be cleared by soft reset anyway, so it takes the async reset too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scratch_q   <= '{default: 8'h00};
      power_ctl_q <= 8'h00;
    end else if (soft_hit) begin
      scratch_q   <= '{default: 8'h00};
      power_ctl_q <= 8'h00;
    end else if (wr_en && is_scratch(ptr_q)) begin
      scratch_q[ptr_q] <= rx_byte;
    end else if (wr_en && (ptr_q == ADDR_POWER_CTL)) begin
      power_ctl_q <= rx_byte;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      write_mode_q <= 1'b0;
      bit_cnt_q    <= 3'd0;
      shift_in_q   <= 7'd0;
      shift_out_q  <= 8'h00;
      ptr_q        <= 6'd0;
      busy_q       <= 1'b0;
    end else begin
      busy_q <= in_frame;
      if (!in_frame) begin
        state_q    <= IDLE;
        bit_cnt_q  <= 3'd0;
        shift_in_q <= 7'd0;
      end else begin
        if (state_q == IDLE) state_q <= CMD;
        if (sclk_rise) begin
          shift_in_q <= rx_byte[6:0];
          bit_cnt_q  <= bit_cnt_q + 3'd1;
        end
        // The fall after the 8th bit sees bit_cnt_q == 0 and leaves the next loaded byte intact.
        if (sclk_fall && (state_q == DATA_RD) && (bit_cnt_q != 3'd0))
          shift_out_q <= {shift_out_q[6:0], 1'b0};
        if (byte_done) begin
          case (state_q)
            CMD: begin
              if (rx_byte == CMD_WRITE) begin
                state_q      <= ADDR;
                write_mode_q <= 1'b1;
              end else if (rx_byte == CMD_READ) begin
                state_q      <= ADDR;
                write_mode_q <= 1'b0;
              end else begin
                state_q <= IGNORE;
              end
            end
            ADDR: begin
              if (write_mode_q) begin
                state_q <= DATA_WR;
                ptr_q   <= rx_byte[5:0];
              end else begin
                state_q     <= DATA_RD;
                shift_out_q <= rd_data;
                ptr_q       <= rx_byte[5:0] + 6'd1;
              end
            end
            DATA_WR: ptr_q <= ptr_q + 6'd1;
            DATA_RD: begin
              shift_out_q <= rd_data;
              ptr_q       <= ptr_q + 6'd1;
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign miso      = (state_q == DATA_RD) ? shift_out_q[7] : 1'b0;
  assign power_ctl = power_ctl_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_spi_responder.sv
// Self-checking bench for spi_responder: directed vector table, corner sequences, random frames vs model.
module tb_spi_responder;

  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk = 1'b0;
  logic       cs = 1'b1;
  logic       mosi = 1'b0;
  logic [7:0] x_data = 8'h00;
  logic [7:0] y_data = 8'h00;
  logic [7:0] z_data = 8'h00;
  logic       miso;
  logic [7:0] power_ctl;
  logic       soft_rst;
  logic       busy;

  always #5 clk = ~clk;

  spi_responder #(.DEVID(8'hAD), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs(cs), .mosi(mosi),
    .x_data(x_data), .y_data(y_data), .z_data(z_data),
    .miso(miso), .power_ctl(power_ctl), .soft_rst(soft_rst), .busy(busy)
  );

  int checks = 0;
  int errors = 0;
  int soft_cnt = 0;

  always @(posedge clk) if (soft_rst === 1'b1) soft_cnt <= soft_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model: register map as plain arrays ----------------
  logic [7:0] mem [64];
  int         soft_exp = 0;
  logic [7:0] tx_buf [8];
  logic [7:0] rx_buf [8];
  logic [7:0] rx_exp [8];
  int         tx_n;

  function automatic logic [7:0] model_read(input int a);
    case (a)
      8'h00:   return 8'hAD;
      8'h01:   return 8'h1D;
      8'h08:   return x_data;
      8'h09:   return y_data;
      8'h0A:   return z_data;
      default: return (a >= 8'h20 && a <= 8'h2D) ? mem[a] : 8'h00;
    endcase
  endfunction

  function automatic void model_write(input int a, input logic [7:0] d);
    if (a >= 8'h20 && a <= 8'h2D) mem[a] = d;
`ifdef SPI_RESP_SOFT_RST_EN
    if (a == 8'h1F && d == 8'h52) begin
      for (int i = 8'h20; i <= 8'h2D; i++) mem[i] = 8'h00;
      soft_exp++;
    end
`endif
  endfunction

  function automatic void model_frame();
    int base;
    for (int i = 0; i < 8; i++) rx_exp[i] = 8'h00;
    if (tx_n >= 2) begin
      base = int'(tx_buf[1][5:0]);
      for (int i = 2; i < tx_n; i++) begin
        if (tx_buf[0] == 8'h0B)      rx_exp[i] = model_read((base + i - 2) % 64);
        else if (tx_buf[0] == 8'h0A) model_write((base + i - 2) % 64, tx_buf[i]);
      end
    end
  endfunction

  // ---------------- SPI master stimulus ----------------
  task automatic xfer_byte(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      mosi = tx[i];
      repeat (HALF) @(negedge clk);
      rx[i] = miso;
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic run_frame();
    cs = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int b = 0; b < tx_n; b++) xfer_byte(tx_buf[b], 8, rx_buf[b]);
    repeat (HALF) @(negedge clk);
    cs = 1'b1;
    mosi = 1'b0;
    repeat (2 * HALF) @(negedge clk);
  endtask

  task automatic load_tx(input logic [63:0] bytes, input int n);
    tx_n = n;
    for (int i = 0; i < 8; i++) tx_buf[i] = bytes[63 - 8*i -: 8];
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    string      name;
    logic [7:0] tx [6];
    int         n;
    logic [7:0] rx [6];
    logic [7:0] pc;
  } vec_t;

  function automatic vec_t mk(input string nm, input logic [47:0] tx, input int n,
                              input logic [47:0] rx, input logic [7:0] pc);
    vec_t v;
    v.name = nm;
    v.n    = n;
    v.pc   = pc;
    for (int i = 0; i < 6; i++) begin
      v.tx[i] = tx[47 - 8*i -: 8];
      v.rx[i] = rx[47 - 8*i -: 8];
    end
    return v;
  endfunction

  vec_t vecs [13];

  initial begin
    logic [7:0] dummy;
    int         s0;
    int         e0;
    int         sel;
    logic [7:0] addr;

    for (int i = 0; i < 64; i++) mem[i] = 8'h00;

    vecs[0]  = mk("wr_pc",     48'h0A2D02_000000, 3, 48'h0,              8'h02);
    vecs[1]  = mk("rd_devid",  48'h0B0000_000000, 4, 48'h0000AD1D_0000,  8'h02);
    vecs[2]  = mk("rd_xyz",    48'h0B0800_000000, 5, 48'h0000112233_00,  8'h02);
    vecs[3]  = mk("wr_scr2c",  48'h0A2C5A_000000, 3, 48'h0,              8'h02);
    vecs[4]  = mk("rd_wrap",   48'h0B3F00_000000, 4, 48'h000000AD_0000,  8'h02);
    vecs[5]  = mk("rd_scr2c",  48'h0B2C00_000000, 3, 48'h00005A_000000,  8'h02);
    vecs[6]  = mk("bad_cmd",   48'h0C2D07_000000, 3, 48'h0,              8'h02);
    vecs[7]  = mk("wr_ro",     48'h0A0055_660000, 4, 48'h0,              8'h02);
    vecs[8]  = mk("rd_ro",     48'h0B0000_000000, 4, 48'h0000AD1D_0000,  8'h02);
    vecs[9]  = mk("wr_hiaddr", 48'h0AED03_000000, 3, 48'h0,              8'h03);
    vecs[10] = mk("rd_hiaddr", 48'h0BED00_000000, 4, 48'h00000300_0000,  8'h03);
    vecs[11] = mk("wr_multi",  48'h0A2BA1_B2C300, 5, 48'h0,              8'hC3);
    vecs[12] = mk("rd_multi",  48'h0B2A00_000000, 6, 48'h000000A1_B2C3,  8'hC3);

    // Reset state
    repeat (3) @(negedge clk);
    check("rst.miso", miso, 1'b0);
    check("rst.busy", busy, 1'b0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("rst.power_ctl", power_ctl, 8'h00);
    check("rst.soft_rst", soft_rst, 1'b0);
    check("rst.busy_after", busy, 1'b0);
    check("rst.miso_after", miso, 1'b0);

    // Directed table
    x_data = 8'h11; y_data = 8'h22; z_data = 8'h33;
    for (int v = 0; v < 13; v++) begin
      tx_n = vecs[v].n;
      for (int i = 0; i < 8; i++) tx_buf[i] = (i < 6) ? vecs[v].tx[i] : 8'h00;
      model_frame();
      run_frame();
      for (int i = 0; i < vecs[v].n; i++)
        check($sformatf("%s.rx%0d", vecs[v].name, i), rx_buf[i], vecs[v].rx[i]);
      check($sformatf("%s.pc", vecs[v].name), power_ctl, vecs[v].pc);
    end

    // Abort mid-byte: partial data byte must be discarded
    cs = 1'b0;
    repeat (HALF) @(negedge clk);
    xfer_byte(8'h0A, 8, dummy);
    xfer_byte(8'h2D, 8, dummy);
    xfer_byte(8'hFF, 5, dummy);
    check("abort.busy_hi", busy, 1'b1);
    cs = 1'b1;
    repeat (2 * HALF) @(negedge clk);
    check("abort.busy_lo", busy, 1'b0);
    check("abort.pc", power_ctl, 8'hC3);
    load_tx(64'h0B2D0000_00000000, 3);
    model_frame();
    run_frame();
    check("abort.recover_rd", rx_buf[2], 8'hC3);

    // Soft reset
    load_tx(64'h0A2D0200_00000000, 3);
    model_frame();
    run_frame();
    check("srst.pre_pc", power_ctl, 8'h02);
    s0 = soft_cnt;
    load_tx(64'h0A1F5200_00000000, 3);
    model_frame();
    run_frame();
    load_tx(64'h0B2C0000_00000000, 4);
    model_frame();
    run_frame();
`ifdef SPI_RESP_SOFT_RST_EN
    check("srst.pc", power_ctl, 8'h00);
    check("srst.pulses", soft_cnt - s0, 1);
    check("srst.scratch", rx_buf[2], 8'h00);
    check("srst.pc_rd", rx_buf[3], 8'h00);
`else
    check("srst.pc", power_ctl, 8'h02);
    check("srst.pulses", soft_cnt - s0, 0);
    check("srst.scratch", rx_buf[2], 8'hB2);
    check("srst.pc_rd", rx_buf[3], 8'h02);
`endif
    load_tx(64'h0B1F0000_00000000, 3);
    model_frame();
    run_frame();
    check("srst.rd_1f", rx_buf[2], 8'h00);

    // Random frames against the model
    s0 = soft_cnt;
    e0 = soft_exp;
    for (int f = 0; f < 30; f++) begin
      x_data = 8'($urandom);
      y_data = 8'($urandom);
      z_data = 8'($urandom);
      sel = $urandom_range(0, 3);
      tx_buf[0] = (sel == 0) ? 8'($urandom) : (sel == 1) ? 8'h0A : 8'h0B;
      case ($urandom_range(0, 2))
        0:       addr = 8'($urandom);
        1:       addr = 8'($urandom_range(8'h1E, 8'h2E)) | {2'($urandom), 6'h00};
        default: addr = 8'($urandom_range(8'h3C, 8'h3F));
      endcase
      tx_buf[1] = addr;
      for (int i = 2; i < 8; i++)
        tx_buf[i] = ($urandom_range(0, 7) == 0) ? 8'h52 : 8'($urandom);
      tx_n = $urandom_range(2, 6);
      model_frame();
      run_frame();
      for (int i = 0; i < tx_n; i++)
        check($sformatf("rand%0d.rx%0d", f, i), rx_buf[i], rx_exp[i]);
      check($sformatf("rand%0d.pc", f), power_ctl, mem[8'h2D]);
    end
    check("rand.soft_pulses", soft_cnt - s0, soft_exp - e0);
    check("end.busy", busy, 1'b0);
    check("end.miso", miso, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
